// File: rtl/bus_term_ctl_if.sv
// bus_term_ctl_if: 68030 strobe, decoder selects, channel straps
// and termination/watchdog/overlay outputs for bus_term_ctl.
//
// Signals:
//   nAS        CPU address strobe, active low
//   SEL        one-hot decoder channel selects, active high
//   WAIT_CFG   per-channel wait-state count, WAIT_W bits each
//   SYNC_MODE  per-channel 1 = STERM, 0 = /DSACKx
//   PORTSZ     per-channel port size, 2 bits each
//   CI_MASK    per-channel cache-inhibit enable
//   STERM      synchronous termination, active high
//   nDSACK     asynchronous termination, active low
//   nBERR      bus error, active low
//   BOOT_OVL   boot-ROM overlay active
//   CI         cache inhibit, active high
interface bus_term_ctl_if #(
  parameter int NCHAN  = 4,
  parameter int WAIT_W = 3
);
  logic                    nAS;
  logic [NCHAN-1:0]        SEL;
  logic [NCHAN*WAIT_W-1:0] WAIT_CFG;
  logic [NCHAN-1:0]        SYNC_MODE;
  logic [2*NCHAN-1:0]      PORTSZ;
  logic [NCHAN-1:0]        CI_MASK;
  logic                    STERM;
  logic [1:0]              nDSACK;
  logic                    nBERR;
  logic                    BOOT_OVL;
  logic                    CI;

  modport master (
    output nAS,
    output SEL,
    output WAIT_CFG,
    output SYNC_MODE,
    output PORTSZ,
    output CI_MASK,
    input  STERM,
    input  nDSACK,
    input  nBERR,
    input  BOOT_OVL,
    input  CI
  );

  modport slave (
    input  nAS,
    input  SEL,
    input  WAIT_CFG,
    input  SYNC_MODE,
    input  PORTSZ,
    input  CI_MASK,
    output STERM,
    output nDSACK,
    output nBERR,
    output BOOT_OVL,
    output CI
  );
endinterface

// File: rtl/bus_term_ctl.sv
// bus_term_ctl: bus-cycle termination (STERM or /DSACKx after
// programmable wait states), /BERR watchdog, boot overlay and CI.
//
// Ports:
//   CPU_CLK  system clock, rising edge
//   nRST     asynchronous active-low reset
//   bus      bus_term_ctl_if.slave (strobe, selects, straps, outputs)
module bus_term_ctl #(
  parameter int NCHAN        = 4,
  parameter int WAIT_W       = 3,
  parameter int BERR_CYCLES  = 64,
  parameter int BOOT_FETCHES = 4
) (
  input logic           CPU_CLK,
  input logic           nRST,
  bus_term_ctl_if.slave bus
);

  localparam int WD_W = $clog2(BERR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TERM,
    S_HOLD
  } state_t;

  state_t state;
  state_t stateNxt;

  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cntNxt;

  logic              chSync;
  logic [1:0]        chSz;

  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wdNxt;
  logic              termSeen;
  logic              termSeenNxt;
  logic [3:0]        bootCnt;
  logic [3:0]        bootCntNxt;

  logic              stermQ;
  logic [1:0]        dsackQ;
  logic              berrQ;
  logic              ovlQ;
  logic              ciQ;

  logic              stermNxt;
  logic [1:0]        dsackNxt;
  logic              berrNxt;
  logic              ovlNxt;
  logic              ciNxt;

  logic              anySel;
  logic [WAIT_W-1:0] pickWait;
  logic              pickSync;
  logic [1:0]        pickSz;
  logic              pickCi;

  logic              start;
  logic              endCyc;
  logic              enterTerm;
  logic              termSync;
  logic [1:0]        termSz;
  logic              berrFire;

  // Lowest-index select wins: scan from the top so the
  // last hit written is the lowest one.
  always_comb begin
    anySel   = 1'b0;
    pickWait = '0;
    pickSync = 1'b0;
    pickSz   = 2'b00;
    pickCi   = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (bus.SEL[i]) begin
        anySel   = 1'b1;
        pickWait = bus.WAIT_CFG[i*WAIT_W +: WAIT_W];
        pickSync = bus.SYNC_MODE[i];
        pickSz   = bus.PORTSZ[2*i +: 2];
        pickCi   = bus.CI_MASK[i];
      end
    end
  end

  assign start  = (state == S_IDLE) && !bus.nAS;
  assign endCyc = (state != S_IDLE) && bus.nAS;

  // State register
  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Next-state logic; nAS high in any busy state ends the cycle
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (!bus.nAS) begin
          if (!anySel) begin
            stateNxt = S_HOLD;
          end else if (pickWait == '0) begin
            stateNxt = S_TERM;
          end else begin
            stateNxt = S_WAIT;
            cntNxt   = pickWait;
          end
        end
      end
      S_WAIT: begin
        if (bus.nAS) begin
          stateNxt = S_IDLE;
        end else if (cnt == WAIT_W'(1)) begin
          stateNxt = S_TERM;
        end else begin
          cntNxt = cnt - WAIT_W'(1);
        end
      end
      S_TERM: begin
        stateNxt = bus.nAS ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (bus.nAS) begin
          stateNxt = S_IDLE;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  // Mode/size come straight from the straps on a zero-wait
  // start, otherwise from the values latched at cycle start.
  assign enterTerm = (stateNxt == S_TERM) && (state != S_TERM);
  assign termSync  = (state == S_IDLE) ? pickSync : chSync;
  assign termSz    = (state == S_IDLE) ? pickSz : chSz;

  // Termination on the firing edge, or any earlier one,
  // keeps /BERR quiet for the rest of the cycle.
  assign berrFire = !bus.nAS &&
                    (wd == WD_W'(BERR_CYCLES - 1)) &&
                    !termSeen && !enterTerm;

  // Output logic: next values of all registered outputs
  always_comb begin
    stermNxt    = enterTerm && termSync;
    dsackNxt    = dsackQ;
    berrNxt     = berrQ;
    wdNxt       = wd;
    termSeenNxt = termSeen;
    bootCntNxt  = bootCnt;
    ciNxt       = ciQ;

    if (stateNxt == S_IDLE) begin
      dsackNxt = 2'b11;
    end else if (enterTerm && !termSync) begin
      dsackNxt = (termSz == 2'b11) ? 2'b00 : termSz;
    end

    if (bus.nAS) begin
      wdNxt       = '0;
      berrNxt     = 1'b1;
      termSeenNxt = 1'b0;
    end else begin
      if (wd != WD_W'(BERR_CYCLES)) begin
        wdNxt = wd + WD_W'(1);
      end
      if (berrFire) begin
        berrNxt = 1'b0;
      end
      termSeenNxt = termSeen | enterTerm;
    end

    if (endCyc && (bootCnt < 4'(BOOT_FETCHES))) begin
      bootCntNxt = bootCnt + 4'd1;
    end
    ovlNxt = bootCntNxt < 4'(BOOT_FETCHES);

    if (start) begin
      ciNxt = ovlQ | (anySel & pickCi);
    end else if (endCyc) begin
      ciNxt = ovlNxt;
    end
  end

  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      chSync   <= 1'b0;
      chSz     <= 2'b00;
      wd       <= '0;
      termSeen <= 1'b0;
      bootCnt  <= 4'd0;
      stermQ   <= 1'b0;
      dsackQ   <= 2'b11;
      berrQ    <= 1'b1;
      ovlQ     <= 1'b1;
      ciQ      <= 1'b1;
    end else begin
      if (start && anySel) begin
        chSync <= pickSync;
        chSz   <= pickSz;
      end
      wd       <= wdNxt;
      termSeen <= termSeenNxt;
      bootCnt  <= bootCntNxt;
      stermQ   <= stermNxt;
      dsackQ   <= dsackNxt;
      berrQ    <= berrNxt;
      ovlQ     <= ovlNxt;
      ciQ      <= ciNxt;
    end
  end

  assign bus.STERM    = stermQ;
  assign bus.nDSACK   = dsackQ;
  assign bus.nBERR    = berrQ;
  assign bus.BOOT_OVL = ovlQ;
  assign bus.CI       = ciQ;

endmodule
